jpeg_pixel_feeder: RTL and testbench

- Streams a stored RGB frame into the jpeg_topfour pixel input: start, pixel_valid, R, G, B.
- Reads the frame from a synchronous-read frame buffer stored in raster order.
- Reorders pixels into 8x8 block order: blocks left-to-right, then top-to-bottom; within a block, row-major.
- After the last pixel, waits for the encoder's done, with a timeout.

---
 rtl/jpeg_pixel_feeder.sv | 157 +++++++++++++++
 tb/tb_jpeg_pixel_feeder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_pixel_feeder.sv
// Streams a raster-order RGB frame buffer to the JPEG encoder in 8x8 block order,
// then waits for the encoder's done with a bounded timeout.
module jpeg_pixel_feeder #(
  parameter int unsigned IMG_W   = 64,
  parameter int unsigned IMG_H   = 64,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              pause,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rdata,
  output logic              start,
  output logic              pixel_valid,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  input  logic              enc_done,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err
);

  localparam int unsigned BX_N   = IMG_W / 8;
  localparam int unsigned BY_N   = IMG_H / 8;
  localparam int unsigned BX_W   = (BX_N > 1) ? $clog2(BX_N) : 1;
  localparam int unsigned BY_W   = (BY_N > 1) ? $clog2(BY_N) : 1;
  localparam int unsigned WCNT_W = 16;

  localparam logic [BX_W-1:0]   BX_LAST   = BX_W'(BX_N - 1);
  localparam logic [BY_W-1:0]   BY_LAST   = BY_W'(BY_N - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, WAIT_DONE} state_t;

  state_t              state, state_nxt;
  logic [2:0]          x, x_nxt, y, y_nxt;
  logic [BX_W-1:0]     bx, bx_nxt;
  logic [BY_W-1:0]     by, by_nxt;
  logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
  logic                rd_nxt, frame_done_nxt, timeout_nxt;
  logic [ADDR_W-1:0]   addr_nxt, cur_addr;
  logic [23:0]         rgb_hold;

  assign cur_addr = ADDR_W'((32'(by) * 32'd8 + 32'(y)) * IMG_W + 32'(bx) * 32'd8 + 32'(x));

  // Pixel is presented in the cycle its read data returns; held otherwise.
  assign R = pixel_valid ? mem_rdata[23:16] : rgb_hold[23:16];
  assign G = pixel_valid ? mem_rdata[15:8]  : rgb_hold[15:8];
  assign B = pixel_valid ? mem_rdata[7:0]   : rgb_hold[7:0];

  // Next-state, read issue and block-order counter advance.
  always_comb begin
    state_nxt      = state;
    x_nxt          = x;
    y_nxt          = y;
    bx_nxt         = bx;
    by_nxt         = by;
    wcnt_nxt       = wcnt;
    rd_nxt         = 1'b0;
    addr_nxt       = mem_addr;
    frame_done_nxt = 1'b0;
    timeout_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = STREAM;
          x_nxt     = '0;
          y_nxt     = '0;
          bx_nxt    = '0;
          by_nxt    = '0;
          wcnt_nxt  = '0;
        end
      end
      STREAM: begin
        // The final read is on the bus this cycle; its pixel emerges in DRAIN.
        if (mem_rd_en && mem_addr == LAST_ADDR) begin
          state_nxt = DRAIN;
        end else if (!pause) begin
          rd_nxt   = 1'b1;
          addr_nxt = cur_addr;
          if (x == 3'd7) begin
            x_nxt = '0;
            if (y == 3'd7) begin
              y_nxt = '0;
              if (bx == BX_LAST) begin
                bx_nxt = '0;
                by_nxt = (by == BY_LAST) ? '0 : by + BY_W'(1);
              end else begin
                bx_nxt = bx + BX_W'(1);
              end
            end else begin
              y_nxt = y + 3'd1;
            end
          end else begin
            x_nxt = x + 3'd1;
          end
        end
      end
      DRAIN: begin
        state_nxt = WAIT_DONE;
        wcnt_nxt  = '0;
      end
      WAIT_DONE: begin
        if (enc_done) begin
          frame_done_nxt = 1'b1;
          state_nxt      = IDLE;
        end else if (wcnt == WAIT_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          wcnt_nxt = wcnt + WCNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      bx          <= '0;
      by          <= '0;
      wcnt        <= '0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      start       <= 1'b0;
      pixel_valid <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      rgb_hold    <= '0;
    end else begin
      state       <= state_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      bx          <= bx_nxt;
      by          <= by_nxt;
      wcnt        <= wcnt_nxt;
      mem_rd_en   <= rd_nxt;
      mem_addr    <= addr_nxt;
      start       <= (state_nxt == STREAM) || (state_nxt == DRAIN);
      pixel_valid <= mem_rd_en;
      busy        <= (state_nxt != IDLE);
      frame_done  <= frame_done_nxt;
      timeout_err <= timeout_nxt;
      if (pixel_valid) rgb_hold <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_jpeg_pixel_feeder.sv
// Bench for jpeg_pixel_feeder: block-order address/pixel model checked every cycle,
// plus directed checks of pause, done/timeout handshake and mid-frame reset.
module tb_jpeg_pixel_feeder;

  localparam int W  = 64;
  localparam int H  = 64;
  localparam int NP = W * H;

  logic        clk = 1'b0;
  logic        rst, go, pause, enc_done;
  logic        mem_rd_en, start, pixel_valid, busy, frame_done, timeout_err;
  logic [11:0] mem_addr;
  logic [23:0] mem_rdata;
  logic [7:0]  R, G, B;

  int n_cmp = 0;
  int n_err = 0;
  int rd_idx = 0;
  int pix_idx = 0;
  int go_count = 0;
  int seen_go = 0;
  logic prev_rd = 1'b0;
  logic [23:0] last_rgb = '0;

  jpeg_pixel_feeder #(.IMG_W(W), .IMG_H(H), .ADDR_W(12), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .go(go), .pause(pause),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .start(start), .pixel_valid(pixel_valid), .R(R), .G(G), .B(B),
    .enc_done(enc_done), .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // k-th pixel of the frame in 8x8 block order -> raster address.
  function automatic int exp_addr(input int k);
    int blk, w;
    blk = k / 64;
    w   = k % 64;
    return ((blk / (W / 8)) * 8 + w / 8) * W + (blk % (W / 8)) * 8 + w % 8;
  endfunction

  function automatic logic [23:0] word(input int a);
    logic [7:0] r, g, b;
    r = 8'(a);
    g = 8'(2 * a);
    b = 8'(3 * a);
    return {r, g, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous-read frame buffer.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= word(int'(mem_addr));

  // Per-cycle compare against the block-order model.
  always @(negedge clk) begin
    if (rst) begin
      rd_idx = 0; pix_idx = 0; prev_rd = 1'b0; last_rgb = '0; seen_go = go_count;
    end else begin
      if (go_count != seen_go) begin
        seen_go = go_count; rd_idx = 0; pix_idx = 0;
      end
      check("pv_latency", 32'(pixel_valid), 32'(prev_rd));
      if (mem_rd_en) begin
        check("rd_addr", 32'(mem_addr), 32'(exp_addr(rd_idx)));
        if (rd_idx == 8)    check("rd8_addr", 32'(mem_addr), 32'd64);
        if (rd_idx == 64)   check("rd64_addr", 32'(mem_addr), 32'd8);
        if (rd_idx == 4095) check("rd4095_addr", 32'(mem_addr), 32'd4095);
        rd_idx++;
      end
      if (pixel_valid) begin
        last_rgb = word(exp_addr(pix_idx));
        check("pixel_rgb", 32'({R, G, B}), 32'(last_rgb));
        if (pix_idx == 9) begin
          check("pix9_R", 32'(R), 32'd65);
          check("pix9_G", 32'(G), 32'd130);
          check("pix9_B", 32'(B), 32'd195);
        end
        pix_idx++;
      end else begin
        check("rgb_hold", 32'({R, G, B}), 32'(last_rgb));
      end
      prev_rd = mem_rd_en;
    end
  end

  task automatic issue_go();
    check("start_before_go", 32'(start), 32'd0);
    go = 1'b1;
    go_count++;
    @(posedge clk); #1;
    go = 1'b0;
    check("start_after_go", 32'(start), 32'd1);
    check("busy_after_go", 32'(busy), 32'd1);
  endtask

  // Runs until start falls; leaves the caller in the first WAIT_DONE cycle.
  task automatic stream_end();
    int cyc, last_pv;
    bit ok;
    cyc = 0; last_pv = -10; ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (pixel_valid) last_pv = cyc;
      if (!start) begin ok = 1'b1; break; end
    end
    check("stream_end_seen", 32'(ok), 32'd1);
    check("start_fall_gap", 32'(cyc - last_pv), 32'd1);
    check("pixel_count", 32'(pix_idx), 32'(NP));
    check("read_count", 32'(rd_idx), 32'(NP));
    check("busy_in_wait", 32'(busy), 32'd1);
  endtask

  task automatic wait_read(input int addr);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (mem_rd_en && int'(mem_addr) == addr) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("wait_read_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got time %0t expected earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] pv_seq;
    int n;
    rst = 1'b0; go = 1'b0; pause = 1'b0; enc_done = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_start", 32'(start), 32'd0);
    check("rst_pv", 32'(pixel_valid), 32'd0);
    check("rst_rd", 32'(mem_rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rgb", 32'({R, G, B}), 32'd0);
    check("rst_flags", 32'({frame_done, timeout_err}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Frame 1: pause after pixel 10 is requested, then enc_done 20 cycles after DRAIN.
    issue_go();
    wait_read(66);
    pause = 1'b1;
    pv_seq = '0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      if (i == 5) pause = 1'b0;
      pv_seq[7 - i] = pixel_valid;
    end
    check("pause_pv_pattern", 32'(pv_seq), 32'b1000001);
    stream_end();
    repeat (19) @(posedge clk);
    #1 enc_done = 1'b1;
    @(posedge clk); #1;
    enc_done = 1'b0;
    check("frame_done_pulse", 32'(frame_done), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
    check("no_timeout", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;
    check("frame_done_one_cycle", 32'(frame_done), 32'd0);

    // Frame 2: restarts at address 0; stray go/enc_done mid-stream ignored; times out.
    issue_go();
    repeat (50) @(posedge clk);
    #1 go = 1'b1; enc_done = 1'b1;
    @(posedge clk); #1;
    go = 1'b0; enc_done = 1'b0;
    stream_end();
    n = 0;
    while (!timeout_err && n < 300) begin
      @(posedge clk); #1;
      n++;
      check("no_frame_done_on_timeout", 32'(frame_done), 32'd0);
    end
    check("timeout_cycles", 32'(n), 32'd100);
    check("busy_after_timeout", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("timeout_one_cycle", 32'(timeout_err), 32'd0);

    // Frame 3: reset at pixel 500.
    issue_go();
    n = 0;
    while (!(pixel_valid && pix_idx == 500) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_pixel_500", 32'(n < 2000), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_start", 32'(start), 32'd0);
    check("midrst_pv", 32'(pixel_valid), 32'd0);
    check("midrst_rd", 32'(mem_rd_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Frame 4: clean stream from address 0 after reset.
    issue_go();
    stream_end();
    enc_done = 1'b1;
    @(posedge clk); #1;
    enc_done = 1'b0;
    check("frame4_done", 32'(frame_done), 32'd1);
    check("frame4_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
